// File: rtl/sr_flag_arbiter_if.sv
// Requester handshakes and SR-bank wiring for sr_flag_arbiter.
// master = requesters + SR bank side, slave = the arbiter.
interface sr_flag_arbiter_if #(
  parameter int N   = 8,
  parameter int IDW = 3
) ();
  logic           a_req;
  logic           a_op;
  logic [IDW-1:0] a_idx;
  logic           a_ack;
  logic           b_req;
  logic           b_op;
  logic [IDW-1:0] b_idx;
  logic           b_ack;
  logic [N-1:0]   s_out;
  logic [N-1:0]   r_out;
  logic [N-1:0]   q_in;
  logic           busy;
  logic           err;

  modport master (
    output a_req, a_op, a_idx, b_req, b_op, b_idx, q_in,
    input  a_ack, b_ack, s_out, r_out, busy, err
  );

  modport slave (
    input  a_req, a_op, a_idx, b_req, b_op, b_idx, q_in,
    output a_ack, b_ack, s_out, r_out, busy, err
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter sharing a bank of N SR flags between two requesters.
// One op per 3 cycles: grant -> s/r pulse -> q check + ack.

// One flag's s/r driver; s and r are only ever loaded as complements of op.
module sr_flag_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  input  logic clr,
  input  logic op,
  output logic s,
  output logic r
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= 1'b0;
      r <= 1'b0;
    end else if (clr) begin
      s <= 1'b0;
      r <= 1'b0;
    end else if (fire) begin
      s <= op;
      r <= !op;
    end
  end
endmodule

module sr_flag_arbiter #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input logic          clk,
  input logic          rst_n,
  sr_flag_arbiter_if.slave bus
);
  localparam int QW = 1 << IDW;
  localparam logic [IDW:0] NLIM = (IDW+1)'(N);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t         state;
  logic           last_b;    // 1: B was served last, so A wins the next tie
  logic           win_b_q;
  logic           op_q;
  logic [IDW-1:0] idx_q;
  logic           ill_q;
  logic           a_ack_q;
  logic           b_ack_q;

  logic           any_req;
  logic           win_b;
  logic           op_w;
  logic [IDW-1:0] idx_w;
  logic           ill_w;
  logic           fire;
  logic [N-1:0]   s_vec;
  logic [N-1:0]   r_vec;
  logic [QW-1:0]  q_ext;

  assign any_req = bus.a_req || bus.b_req;
  assign win_b   = bus.b_req && (!bus.a_req || !last_b);
  assign op_w    = win_b ? bus.b_op  : bus.a_op;
  assign idx_w   = win_b ? bus.b_idx : bus.a_idx;
  assign ill_w   = {1'b0, idx_w} >= NLIM;
  assign fire    = (state == IDLE) && any_req && !ill_w;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sr_flag_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .fire (fire && (idx_w == IDW'(i))),
      .clr  (state == DRIVE),
      .op   (op_w),
      .s    (s_vec[i]),
      .r    (r_vec[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      win_b_q <= 1'b0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      ill_q   <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          if (any_req) begin
            last_b  <= win_b;
            win_b_q <= win_b;
            op_q    <= op_w;
            idx_q   <= idx_w;
            ill_q   <= ill_w;
            if (ill_w) begin
              state   <= CHECK;
              a_ack_q <= !win_b;
              b_ack_q <= win_b;
            end else begin
              state <= DRIVE;
            end
          end
        end
        DRIVE: begin
          state   <= CHECK;
          a_ack_q <= !win_b_q;
          b_ack_q <= win_b_q;
        end
        default: begin
          state   <= IDLE;
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // q only settles after the pulse edge, so err is judged live in CHECK
  assign q_ext     = QW'(bus.q_in);
  assign bus.err   = (state == CHECK) && (ill_q || (q_ext[idx_q] != op_q));
  assign bus.busy  = (state != IDLE);
  assign bus.a_ack = a_ack_q;
  assign bus.b_ack = b_ack_q;
  assign bus.s_out = s_vec;
  assign bus.r_out = r_vec;
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed + random bench for sr_flag_arbiter with an SR bank model (N=6).
module tb_sr_flag_arbiter;
  localparam int N = 6;
  localparam int IDW = 3;

  logic clk;
  logic rst_n;
  sr_flag_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  sr_flag_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] q_bank = '0;
  logic [N-1:0] force_mask = '0;
  assign bus.q_in = q_bank & ~force_mask;

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (bus.s_out[i]) q_bank[i] <= 1'b1;
      else if (bus.r_out[i]) q_bank[i] <= 1'b0;

  typedef struct packed {
    logic       who;   // 0 = A, 1 = B
    logic       op;
    logic [2:0] idx;
    logic       err;
    logic       ill;
  } exp_t;

  exp_t ack_q[$];
  int   vectors = 0;
  int   errs = 0;
  bit   sb_on = 1'b1;
  bit   drv_seen = 1'b0;
  int   busy_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [N-1:0] es, er;
    busy_cnt = bus.busy ? busy_cnt + 1 : 0;
    chk("sr_overlap", 32'(bus.s_out & bus.r_out), 0);
    chk("sr_onehot", 32'($countones(bus.s_out | bus.r_out) <= 1), 1);
    if (sb_on) begin
      if (|(bus.s_out | bus.r_out)) begin
        if (ack_q.size() == 0) chk("unexp_drive", 32'(bus.s_out | bus.r_out), 0);
        else begin
          e  = ack_q[0];
          es = (!e.ill && e.op)  ? (6'b1 << e.idx) : '0;
          er = (!e.ill && !e.op) ? (6'b1 << e.idx) : '0;
          chk("drive_s", 32'(bus.s_out), 32'(es));
          chk("drive_r", 32'(bus.r_out), 32'(er));
          chk("drive_cyc", busy_cnt, 1);
          chk("dup_drive", 32'(drv_seen), 0);
          drv_seen = 1'b1;
        end
      end
      if (bus.a_ack || bus.b_ack) begin
        if (ack_q.size() == 0) chk("unexp_ack", {bus.a_ack, bus.b_ack}, 0);
        else begin
          e = ack_q.pop_front();
          chk("ack_who", {bus.a_ack, bus.b_ack}, e.who ? 2'b01 : 2'b10);
          chk("ack_err", 32'(bus.err), 32'(e.err));
          chk("ack_cyc", busy_cnt, e.ill ? 1 : 2);
          chk("drive_seen", 32'(drv_seen), 32'(!e.ill));
          drv_seen = 1'b0;
        end
      end else chk("err_no_ack", 32'(bus.err), 0);
    end
  end

  task automatic push(input logic who, input logic op, input logic [2:0] idx, input logic err);
    exp_t e;
    e.who = who; e.op = op; e.idx = idx; e.err = err;
    e.ill = (idx >= 3'(N));
    ack_q.push_back(e);
  endtask

  task automatic wait_ack(input logic who);
    int n;
    logic got;
    got = 1'b0;
    for (n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      got = who ? bus.b_ack : bus.a_ack;
    end
    chk(who ? "b_ack_timeout" : "a_ack_timeout", 32'(got), 1);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 20 && ack_q.size() != 0; n++) @(posedge clk);
    chk("drain_timeout", ack_q.size(), 0);
  endtask

  task automatic do_op(input logic who, input logic op, input logic [2:0] idx, input logic err);
    push(who, op, idx, err);
    @(posedge clk); #1;
    if (!who) begin bus.a_req = 1'b1; bus.a_op = op; bus.a_idx = idx; end
    else      begin bus.b_req = 1'b1; bus.b_op = op; bus.b_idx = idx; end
    wait_ack(who);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    drain();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.a_req = 1'b0; bus.a_op = 1'b0; bus.a_idx = '0;
    bus.b_req = 1'b0; bus.b_op = 1'b0; bus.b_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s", 32'(bus.s_out), 0);
    chk("rst_r", 32'(bus.r_out), 0);
    chk("rst_ack", {bus.a_ack, bus.b_ack}, 0);
    chk("rst_busy_err", {bus.busy, bus.err}, 0);
    rst_n = 1'b1;

    // single set, repeat set (already satisfied), clear
    do_op(1'b0, 1'b1, 3'd3, 1'b0);
    chk("q3_set", 32'(bus.q_in[3]), 1);
    do_op(1'b0, 1'b1, 3'd3, 1'b0);
    do_op(1'b0, 1'b0, 3'd3, 1'b0);
    chk("q3_clr", 32'(bus.q_in[3]), 0);

    // stuck-low flag 2 makes the check fail
    force_mask = 6'b000100;
    do_op(1'b0, 1'b1, 3'd2, 1'b1);
    force_mask = '0;

    // illegal index: ack after one cycle, no pulse
    do_op(1'b1, 1'b1, 3'd7, 1'b1);

    // reset while the pulse is on the bank
    push(1'b0, 1'b1, 3'd4, 1'b0);
    @(posedge clk); #1;
    bus.a_req = 1'b1; bus.a_op = 1'b1; bus.a_idx = 3'd4;
    for (n = 0; n < 10 && !(|bus.s_out); n++) begin @(posedge clk); #1; end
    chk("mid_drive_seen", 32'(bus.s_out), 32'(6'b010000));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s", 32'(bus.s_out), 0);
    chk("mid_rst_r", 32'(bus.r_out), 0);
    chk("mid_rst_ack_busy", {bus.a_ack, bus.b_ack, bus.busy}, 0);
    ack_q.delete();
    drv_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("q4_not_set", 32'(bus.q_in[4]), 0);
    push(1'b0, 1'b1, 3'd4, 1'b0);
    rst_n = 1'b1;
    wait_ack(1'b0);
    bus.a_req = 1'b0;
    drain();
    chk("q4_set", 32'(bus.q_in[4]), 1);

    // tie from fresh reset: A, B, A, B on the same flag with opposite ops
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push(1'b0, 1'b0, 3'd5, 1'b0);
      push(1'b1, 1'b1, 3'd5, 1'b0);
    end
    bus.a_req = 1'b1; bus.a_op = 1'b0; bus.a_idx = 3'd5;
    bus.b_req = 1'b1; bus.b_op = 1'b1; bus.b_idx = 3'd5;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (bus.a_ack || bus.b_ack) n++;
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    chk("tie_acks", n, 4);
    drain();
    chk("q5_last_b", 32'(bus.q_in[5]), 1);

    // random traffic, forbidden-state guard only
    sb_on = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (bus.a_req && bus.a_ack) bus.a_req = 1'b0;
      else if (!bus.a_req && $urandom_range(0, 1) == 1) begin
        bus.a_req = 1'b1; bus.a_op = 1'($urandom_range(0, 1)); bus.a_idx = 3'($urandom_range(0, 7));
      end
      if (bus.b_req && bus.b_ack) bus.b_req = 1'b0;
      else if (!bus.b_req && $urandom_range(0, 1) == 1) begin
        bus.b_req = 1'b1; bus.b_op = 1'($urandom_range(0, 1)); bus.b_idx = 3'($urandom_range(0, 7));
      end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    for (n = 0; n < 10 && bus.busy; n++) begin @(posedge clk); #1; end
    chk("rand_idle", 32'(bus.busy), 0);
    @(posedge clk); #1;
    sb_on = 1'b1;

    do_op(1'b1, 1'b1, 3'd0, 1'b0);
    chk("q0_set", 32'(bus.q_in[0]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
